// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of the single-port data memory.
// CPU has priority; the aux port is forced through after MAX_WAIT lost rounds.
module dmem_port_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic [DATA_W-1:0] aux_rdata,
  output logic              aux_ack,
  output logic              ram_en,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_adr,
  output logic [DATA_W-1:0] ram_wdat,
  input  logic [DATA_W-1:0] ram_rdat,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_ACK
  } state_e;

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  state_e            state_q, state_d;
  logic [3:0]        wait_q, wait_d;
  logic              grant, grant_aux;
  logic              owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cpu_rd_q;
  logic [DATA_W-1:0] aux_rd_q;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    grant     = 1'b0;
    grant_aux = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (aux_req && (!cpu_req || wait_q == MAX_W)) begin
          grant     = 1'b1;
          grant_aux = 1'b1;
          wait_d    = '0;
          state_d   = S_ACCESS;
        end else if (cpu_req) begin
          grant   = 1'b1;
          state_d = S_ACCESS;
          // Saturate so aux wins the very next contested round
          if (aux_req && wait_q != MAX_W)
            wait_d = wait_q + 4'd1;
        end
      end
      S_ACCESS: state_d = S_WAIT;
      S_WAIT:   state_d = S_ACK;
      S_ACK:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cpu_rd_q <= '0;
      aux_rd_q <= '0;
    end else begin
      if (grant) begin
        owner_q <= grant_aux;
        we_q    <= grant_aux ? aux_we : cpu_we;
        addr_q  <= grant_aux ? aux_addr : cpu_addr;
        wdata_q <= grant_aux ? aux_wdata : cpu_wdata;
      end
      if (state_q == S_WAIT && !we_q) begin
        if (owner_q) aux_rd_q <= ram_rdat;
        else         cpu_rd_q <= ram_rdat;
      end
    end
  end

  always_comb begin
    ram_en  = (state_q == S_ACCESS);
    ram_wen = (state_q == S_ACCESS) && we_q;
    cpu_ack = (state_q == S_ACK) && !owner_q;
    aux_ack = (state_q == S_ACK) && owner_q;
    busy    = (state_q != S_IDLE);
  end

  // Latched request doubles as the memory-side hold register
  assign ram_adr   = addr_q;
  assign ram_wdat  = wdata_q;
  assign cpu_rdata = cpu_rd_q;
  assign aux_rdata = aux_rd_q;

endmodule
